// File: rtl/voice_allocator.sv
// Voice allocator: maps MIDI note-on/off requests onto N oscillator voices.
// It scans one voice per clock and handles retrigger, lowest-free and oldest-steal selection.
module voice_allocator #(
    parameter int N     = 75,
    parameter int AGE_W = 7
) (
    input  logic         MHz10,
    input  logic         nrst,
    input  logic         en,
    input  logic         clear,
    input  logic         note_on,
    input  logic         note_off,
    input  logic [6:0]   note,
    input  logic [N-1:0] avail,
    output logic [N-1:0] start_out,
    output logic [N-1:0] stop_out,
    output logic         stolen,
    output logic         busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SCAN_ON, SCAN_OFF, GRANT} state_t;
    typedef enum logic [1:0] {K_NONE, K_MATCH, K_FREE, K_STEAL} kind_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [6:0]         note_reg, note_next;
    logic               grant_on_reg, grant_on_next;
    logic               pend_vld_reg, pend_vld_next;
    logic [6:0]         pend_note_reg, pend_note_next;
    logic               match_vld_reg, match_vld_next;
    logic [IDX_W-1:0]   match_idx_reg, match_idx_next;
    logic               free_vld_reg, free_vld_next;
    logic [IDX_W-1:0]   free_idx_reg, free_idx_next;
    logic               steal_vld_reg, steal_vld_next;
    logic [IDX_W-1:0]   steal_idx_reg, steal_idx_next;
    logic [AGE_W-1:0]   steal_age_reg, steal_age_next;
    logic [IDX_W-1:0]   sel_reg, sel_next;
    kind_t              kind_reg, kind_next;

    logic [6:0]         note_tbl_reg [N];
    logic [AGE_W-1:0]   age_reg [N];

    logic cur_active;
    logic grant_on_fire;
    logic start_fire;
    logic stop_fire;

    assign cur_active    = ~avail[idx_reg];
    assign grant_on_fire = en && (state_reg == GRANT) && grant_on_reg;
    assign start_fire    = grant_on_fire && (kind_reg != K_NONE);
    assign stop_fire     = en && (state_reg == GRANT) && !grant_on_reg && (kind_reg == K_MATCH);
    assign stolen        = grant_on_fire && (kind_reg == K_STEAL);
    assign busy          = (state_reg != IDLE);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pulse
            assign start_out[gi] = start_fire && (sel_reg == IDX_W'(gi));
            assign stop_out[gi]  = stop_fire && (sel_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        note_next      = note_reg;
        grant_on_next  = grant_on_reg;
        pend_vld_next  = pend_vld_reg;
        pend_note_next = pend_note_reg;
        match_vld_next = match_vld_reg;
        match_idx_next = match_idx_reg;
        free_vld_next  = free_vld_reg;
        free_idx_next  = free_idx_reg;
        steal_vld_next = steal_vld_reg;
        steal_idx_next = steal_idx_reg;
        steal_age_next = steal_age_reg;
        sel_next       = sel_reg;
        kind_next      = kind_reg;

        case (state_reg)
            IDLE: begin
                idx_next       = '0;
                match_vld_next = 1'b0;
                free_vld_next  = 1'b0;
                steal_vld_next = 1'b0;
                // A parked note-on wins over fresh requests, which are dropped this cycle
                if (pend_vld_reg) begin
                    state_next    = SCAN_ON;
                    note_next     = pend_note_reg;
                    grant_on_next = 1'b1;
                    pend_vld_next = 1'b0;
                end else if (note_off) begin
                    state_next    = SCAN_OFF;
                    note_next     = note;
                    grant_on_next = 1'b0;
                    if (note_on) begin
                        pend_vld_next  = 1'b1;
                        pend_note_next = note;
                    end
                end else if (note_on) begin
                    state_next    = SCAN_ON;
                    note_next     = note;
                    grant_on_next = 1'b1;
                end
            end
            SCAN_ON, SCAN_OFF: begin
                if (cur_active && (note_tbl_reg[idx_reg] == note_reg) && !match_vld_reg) begin
                    match_vld_next = 1'b1;
                    match_idx_next = idx_reg;
                end
                if (!cur_active && !free_vld_reg) begin
                    free_vld_next = 1'b1;
                    free_idx_next = idx_reg;
                end
                // Strict greater-than keeps the lowest index on equal ages
                if (cur_active && (!steal_vld_reg || (age_reg[idx_reg] > steal_age_reg))) begin
                    steal_vld_next = 1'b1;
                    steal_idx_next = idx_reg;
                    steal_age_next = age_reg[idx_reg];
                end
                idx_next = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = GRANT;
                    idx_next   = '0;
                    kind_next  = K_NONE;
                    if (match_vld_next) begin
                        kind_next = K_MATCH;
                        sel_next  = match_idx_next;
                    end else if ((state_reg == SCAN_ON) && free_vld_next) begin
                        kind_next = K_FREE;
                        sel_next  = free_idx_next;
                    end else if ((state_reg == SCAN_ON) && steal_vld_next) begin
                        kind_next = K_STEAL;
                        sel_next  = steal_idx_next;
                    end
                end
            end
            GRANT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst || clear) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            note_reg      <= '0;
            grant_on_reg  <= 1'b0;
            pend_vld_reg  <= 1'b0;
            pend_note_reg <= '0;
            match_vld_reg <= 1'b0;
            match_idx_reg <= '0;
            free_vld_reg  <= 1'b0;
            free_idx_reg  <= '0;
            steal_vld_reg <= 1'b0;
            steal_idx_reg <= '0;
            steal_age_reg <= '0;
            sel_reg       <= '0;
            kind_reg      <= K_NONE;
        end else if (en) begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            note_reg      <= note_next;
            grant_on_reg  <= grant_on_next;
            pend_vld_reg  <= pend_vld_next;
            pend_note_reg <= pend_note_next;
            match_vld_reg <= match_vld_next;
            match_idx_reg <= match_idx_next;
            free_vld_reg  <= free_vld_next;
            free_idx_reg  <= free_idx_next;
            steal_vld_reg <= steal_vld_next;
            steal_idx_reg <= steal_idx_next;
            steal_age_reg <= steal_age_next;
            sel_reg       <= sel_next;
            kind_reg      <= kind_next;
        end
    end

    // Granted voice becomes newest; every other sounding voice ages by one
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst || clear) begin
            for (int i = 0; i < N; i++) begin
                note_tbl_reg[i] <= '0;
                age_reg[i]      <= '0;
            end
        end else if (grant_on_fire) begin
            for (int i = 0; i < N; i++) begin
                if (sel_reg == IDX_W'(i)) begin
                    note_tbl_reg[i] <= note_reg;
                    age_reg[i]      <= '0;
                end else if (!avail[i] && (age_reg[i] != AGE_MAX)) begin
                    age_reg[i] <= age_reg[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (N=4, AGE_W=2).
// Expected pulses are queued at request time and compared on their due cycle.
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int N     = 4;
    localparam int AGE_W = 2;

    logic         MHz10    = 1'b0;
    logic         nrst     = 1'b0;
    logic         en       = 1'b1;
    logic         clear    = 1'b0;
    logic         note_on  = 1'b0;
    logic         note_off = 1'b0;
    logic [6:0]   note     = '0;
    logic [N-1:0] avail    = '1;
    logic [N-1:0] start_out;
    logic [N-1:0] stop_out;
    logic         stolen;
    logic         busy;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int issue_cyc = 0;
    bit busy_chk  = 0;

    typedef struct {
        int           due;
        logic [N-1:0] start;
        logic [N-1:0] stop;
        logic         stl;
    } exp_t;
    exp_t sb[$];

    voice_allocator #(.N(N), .AGE_W(AGE_W)) dut (
        .MHz10     (MHz10),
        .nrst      (nrst),
        .en        (en),
        .clear     (clear),
        .note_on   (note_on),
        .note_off  (note_off),
        .note      (note),
        .avail     (avail),
        .start_out (start_out),
        .stop_out  (stop_out),
        .stolen    (stolen),
        .busy      (busy)
    );

    always #50 MHz10 = ~MHz10;
    always @(posedge MHz10) cyc <= cyc + 1;

    // Called at a falling edge; request is held for exactly one cycle
    task automatic issue(input logic on, input logic off, input logic [6:0] n);
        note_on   = on;
        note_off  = off;
        note      = n;
        issue_cyc = cyc;
        @(posedge MHz10);
        #1;
        note_on  = 1'b0;
        note_off = 1'b0;
    endtask

    task automatic push_exp(input int lat, input logic [N-1:0] s, input logic [N-1:0] p, input logic st);
        exp_t e;
        e.due   = issue_cyc + lat;
        e.start = s;
        e.stop  = p;
        e.stl   = st;
        sb.push_back(e);
    endtask

    task automatic watch(input int n);
        exp_t e;
        logic eb;
        int   rel;
        for (int k = 0; k < n; k++) begin
            @(negedge MHz10);
            rel = cyc - issue_cyc;
            if (busy_chk) begin
                eb = (rel >= 1) && (rel <= N + 1);
                checks++;
                if (busy !== eb) begin
                    errors++;
                    $display("FAIL busy t+%0d: got %b want %b", rel, busy, eb);
                end
            end
            if (sb.size() > 0 && cyc >= sb[0].due) begin
                e = sb.pop_front();
                checks++;
                if (start_out !== e.start || stop_out !== e.stop || stolen !== e.stl) begin
                    errors++;
                    $display("FAIL pulse t+%0d: start=%b stop=%b stolen=%b want start=%b stop=%b stolen=%b",
                             rel, start_out, stop_out, stolen, e.start, e.stop, e.stl);
                end
            end else begin
                checks++;
                if (start_out !== '0 || stop_out !== '0 || stolen !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_pulse t+%0d: start=%b stop=%b stolen=%b want all 0",
                             rel, start_out, stop_out, stolen);
                end
            end
        end
    endtask

    task automatic drain;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pulses never seen, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic pulse_reset;
        nrst = 1'b0;
        @(negedge MHz10);
        nrst = 1'b1;
        @(negedge MHz10);
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (3) @(negedge MHz10);
        checks += 4;
        if (start_out !== '0) begin errors++; $display("FAIL reset_start: got %b want 0", start_out); end
        if (stop_out !== '0)  begin errors++; $display("FAIL reset_stop: got %b want 0", stop_out); end
        if (stolen !== 1'b0)  begin errors++; $display("FAIL reset_stolen: got %b want 0", stolen); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        nrst = 1'b1;
        @(negedge MHz10);
        $display("test_reset done");
    endtask

    task automatic test_first_note;
        avail    = 4'b1111;
        busy_chk = 1;
        issue(1'b1, 1'b0, 7'd60);
        push_exp(N + 1, 4'b0001, 4'b0000, 1'b0);
        watch(1);
        note_on = 1'b1;          // arrives mid-scan, must be dropped
        note    = 7'd61;
        watch(1);
        note_on = 1'b0;
        watch(8);
        busy_chk = 0;
        drain();
        avail = 4'b1110;
        $display("test_first_note done");
    endtask

    task automatic test_lowest_free;
        issue(1'b1, 1'b0, 7'd62);
        push_exp(N + 1, 4'b0010, 4'b0000, 1'b0);
        watch(7);
        avail = 4'b1100;
        issue(1'b1, 1'b0, 7'd64);
        push_exp(N + 1, 4'b0100, 4'b0000, 1'b0);
        watch(7);
        drain();
        checks += 4;
        if (dut.age_reg[0] !== 2'd2) begin errors++; $display("FAIL age_v0: got %0d want 2", dut.age_reg[0]); end
        if (dut.age_reg[1] !== 2'd1) begin errors++; $display("FAIL age_v1: got %0d want 1", dut.age_reg[1]); end
        if (dut.age_reg[2] !== 2'd0) begin errors++; $display("FAIL age_v2: got %0d want 0", dut.age_reg[2]); end
        if (dut.note_tbl_reg[2] !== 7'd64) begin errors++; $display("FAIL note_v2: got %0d want 64", dut.note_tbl_reg[2]); end
        avail = 4'b1000;
        $display("test_lowest_free done");
    endtask

    task automatic test_steal;
        issue(1'b1, 1'b0, 7'd65);
        push_exp(N + 1, 4'b1000, 4'b0000, 1'b0);
        watch(7);
        avail = 4'b0000;
        issue(1'b1, 1'b0, 7'd67);
        push_exp(N + 1, 4'b0001, 4'b0000, 1'b1);
        watch(7);
        drain();
        checks += 2;
        if (dut.note_tbl_reg[0] !== 7'd67) begin errors++; $display("FAIL steal_note_v0: got %0d want 67", dut.note_tbl_reg[0]); end
        if (dut.age_reg[1] !== 2'd3) begin errors++; $display("FAIL age_sat_v1: got %0d want 3", dut.age_reg[1]); end
        $display("test_steal done");
    endtask

    task automatic test_retrigger;
        issue(1'b1, 1'b0, 7'd62);
        push_exp(N + 1, 4'b0010, 4'b0000, 1'b0);
        watch(7);
        issue(1'b0, 1'b1, 7'd62);
        push_exp(N + 1, 4'b0000, 4'b0010, 1'b0);
        watch(7);
        drain();
        $display("test_retrigger done");
    endtask

    task automatic test_on_off_same_cycle;
        pulse_reset();
        avail = 4'b1111;
        issue(1'b1, 1'b0, 7'd60);
        push_exp(N + 1, 4'b0001, 4'b0000, 1'b0);
        watch(7);
        avail = 4'b1110;
        issue(1'b1, 1'b1, 7'd60);
        push_exp(N + 1, 4'b0000, 4'b0001, 1'b0);
        push_exp(2 * N + 3, 4'b0001, 4'b0000, 1'b0);
        watch(13);
        drain();
        $display("test_on_off_same_cycle done");
    endtask

    task automatic test_en_freeze;
        pulse_reset();
        avail = 4'b1111;
        issue(1'b1, 1'b0, 7'd50);
        push_exp(N + 4, 4'b0001, 4'b0000, 1'b0);
        watch(2);
        en = 1'b0;
        watch(3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL freeze_busy: got %b want 1", busy); end
        en = 1'b1;
        watch(6);
        drain();
        $display("test_en_freeze done");
    endtask

    task automatic test_clear;
        issue(1'b1, 1'b0, 7'd40);
        watch(2);
        clear = 1'b1;
        watch(1);
        clear = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
        if (dut.note_tbl_reg[0] !== 7'd0) begin errors++; $display("FAIL clear_note_v0: got %0d want 0", dut.note_tbl_reg[0]); end
        watch(8);
        drain();
        $display("test_clear done");
    endtask

    task automatic test_reset_midscan;
        avail = 4'b1111;
        issue(1'b1, 1'b0, 7'd30);
        watch(3);
        nrst = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        if (start_out !== '0 || stop_out !== '0) begin
            errors++;
            $display("FAIL midreset_pulses: start=%b stop=%b want 0", start_out, stop_out);
        end
        if (stolen !== 1'b0) begin errors++; $display("FAIL midreset_stolen: got %b want 0", stolen); end
        @(negedge MHz10);
        nrst = 1'b1;
        watch(6);
        busy_chk = 1;
        issue(1'b0, 1'b1, 7'd99);
        watch(8);
        busy_chk = 0;
        drain();
        $display("test_reset_midscan done");
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_lowest_free();
        test_steal();
        test_retrigger();
        test_on_off_same_cycle();
        test_en_freeze();
        test_clear();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
